// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARBITER_STATS_EN to add the saturating stall_cnt output.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_wr_data,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  owner
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [15:0]                 stall_cnt
`endif
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] lastOwner_q, lastOwner_d;
    logic [BW-1:0] beatCnt_q, beatCnt_d;

    logic [OW-1:0] chosen;
    logic [OW-1:0] scanIdx;
    logic          found;
    logic          ownerReq;
    logic          accept;

    // Scan starts just after the previous grantee and wraps, giving round-robin fairness.
    always_comb begin
        chosen  = lastOwner_q;
        found   = 1'b0;
        scanIdx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scanIdx = OW'((int'(lastOwner_q) + k) % NUM_REQ);
            if (!found && req[scanIdx]) begin
                found  = 1'b1;
                chosen = scanIdx;
            end
        end
    end

    always_comb begin
        ownerReq     = 1'b0;
        fifo_wr_data = req_data[DATA_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                ownerReq     = req[i];
                fifo_wr_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept  = (state_q == BURST) && ownerReq && !fifo_full;
    assign fifo_wr = accept;
    assign busy    = (state_q == BURST);
    assign owner   = owner_q;

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = accept && (owner_q == OW'(i));
        end
    end

    // A release takes priority over a full FIFO; a stall simply holds everything.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        beatCnt_d   = beatCnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d   = BURST;
                    owner_d   = chosen;
                    beatCnt_d = '0;
                end
            end
            BURST: begin
                if (!ownerReq) begin
                    state_d     = IDLE;
                    lastOwner_d = owner_q;
                end else if (accept) begin
                    beatCnt_d = beatCnt_q + BW'(1);
                    if (beatCnt_q == BW'(MAX_BURST - 1)) begin
                        state_d     = IDLE;
                        lastOwner_d = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastOwner_q <= OW'(NUM_REQ - 1);
            beatCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            beatCnt_q   <= beatCnt_d;
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] stallCnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q <= '0;
        end else if (busy && ownerReq && fifo_full && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_q <= stallCnt_q + 16'd1;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed producer traffic, expected writes and status queued per cycle.
// Stall counter checks are active when FIFO_WR_ARBITER_STATS_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  gnt;
    logic        fifoFull;
    logic        fifoWr;
    logic [7:0]  fifoWrData;
    logic        busy;
    logic [1:0]  owner;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] stallCnt;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (reqData),
        .gnt         (gnt),
        .fifo_full   (fifoFull),
        .fifo_wr     (fifoWr),
        .fifo_wr_data(fifoWrData),
        .busy        (busy),
        .owner       (owner)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .stall_cnt   (stallCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] expGnt;
        logic [7:0] expData;
    } wrExp_t;

    typedef struct {
        int         cyc;
        logic       expBusy;
        logic [1:0] expOwner;
        logic [3:0] expGnt;
        logic       expWr;
        logic       chkData;
        logic [7:0] expData;
        logic       chkStall;
        logic [15:0] expStall;
    } stExp_t;

    wrExp_t     wrQ[$];
    stExp_t     stQ[$];
    logic [7:0] prodQ [4][$];

    int   cycle     = 0;
    int   vecCount  = 0;
    int   missCount = 0;
    logic doneReq   = 1'b0;

    // Each producer presents the head of its queue and holds req while data remains.
    task automatic driveProducers();
        for (int i = 0; i < 4; i++) begin
            req[i] = (prodQ[i].size() > 0);
            reqData[i*8 +: 8] = req[i] ? prodQ[i][0] : 8'h00;
        end
    endtask

    // Advance one clock; a producer granted in the finished cycle moves to its next word.
    task automatic tick();
        logic [3:0] g;
        logic [7:0] dummy;
        @(negedge clk);
        g = gnt;
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < 4; i++) begin
            if (g[i] && prodQ[i].size() > 0) dummy = prodQ[i].pop_front();
        end
        driveProducers();
    endtask

    task automatic expectWrite(input int c, input int who, input logic [7:0] d);
        wrExp_t w;
        w.cyc     = c;
        w.expGnt  = 4'(1 << who);
        w.expData = d;
        wrQ.push_back(w);
    endtask

    task automatic pushCheck(input int c, input logic b, input logic [1:0] o, input logic [3:0] g,
                             input logic w, input logic cd, input logic [7:0] d,
                             input logic cs, input logic [15:0] s);
        stExp_t e;
        e.cyc      = c;
        e.expBusy  = b;
        e.expOwner = o;
        e.expGnt   = g;
        e.expWr    = w;
        e.chkData  = cd;
        e.expData  = d;
        e.chkStall = cs;
        e.expStall = s;
        stQ.push_back(e);
    endtask

    task automatic expectStatus(input int c, input logic b, input logic [1:0] o, input logic [3:0] g, input logic w);
        pushCheck(c, b, o, g, w, 1'b0, 8'h00, 1'b0, 16'h0000);
    endtask

    task automatic expectStall(input int c, input logic b, input logic [1:0] o, input logic [15:0] s);
        pushCheck(c, b, o, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b1, s);
    endtask

    task automatic startReset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) prodQ[i].delete();
        driveProducers();
        expectStall(cycle, 1'b0, 2'd0, 16'h0000);
        tick();
        tick();
    endtask

    task automatic releaseReset(output int b);
        rst = 1'b0;
        b   = cycle;
    endtask

    task automatic applyStimulus();
        int         b;
        int         b2;
        int         owners [5];
        logic [7:0] firstData [5];

        // Single requester, clean 4-beat burst.
        startReset();
        for (int j = 0; j < 4; j++) prodQ[0].push_back(8'(8'hA0 + j));
        driveProducers();
        releaseReset(b);
        pushCheck(b, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 8'hA0, 1'b0, 16'h0000);
        expectStatus(b + 1, 1'b1, 2'd0, 4'b0001, 1'b1);
        for (int j = 0; j < 4; j++) expectWrite(b + 1 + j, 0, 8'(8'hA0 + j));
        expectStatus(b + 5, 1'b0, 2'd0, 4'b0000, 1'b0);
        repeat (7) tick();

        // All four requesting: order 0,1,2,3,0 with one idle cycle between bursts.
        startReset();
        for (int j = 0; j < 8; j++) prodQ[0].push_back(8'(8'h10 + j));
        for (int j = 0; j < 4; j++) prodQ[1].push_back(8'(8'h20 + j));
        for (int j = 0; j < 4; j++) prodQ[2].push_back(8'(8'h30 + j));
        for (int j = 0; j < 4; j++) prodQ[3].push_back(8'(8'h40 + j));
        driveProducers();
        releaseReset(b);
        owners    = '{0, 1, 2, 3, 0};
        firstData = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h14};
        for (int n = 0; n < 5; n++) begin
            for (int j = 0; j < 4; j++) expectWrite(b + 1 + 5*n + j, owners[n], 8'(firstData[n] + j));
        end
        expectStatus(b + 5,  1'b0, 2'd0, 4'b0000, 1'b0);
        expectStatus(b + 20, 1'b0, 2'd3, 4'b0000, 1'b0);
        expectStatus(b + 25, 1'b0, 2'd0, 4'b0000, 1'b0);
        repeat (27) tick();

        // Requester 1 stalled by a full FIFO for three cycles mid-burst.
        startReset();
        for (int j = 0; j < 4; j++) prodQ[1].push_back(8'(8'h50 + j));
        driveProducers();
        releaseReset(b);
        expectWrite(b + 1, 1, 8'h50);
        for (int j = 1; j < 4; j++) expectWrite(b + 4 + j, 1, 8'(8'h50 + j));
        expectStall(b + 3, 1'b1, 2'd1, 16'd1);
        expectStall(b + 8, 1'b0, 2'd1, 16'd3);
        tick();
        tick();
        fifoFull = 1'b1;
        repeat (3) tick();
        fifoFull = 1'b0;
        repeat (5) tick();

        // Requester 2 releases after two beats; requester 3 then gets a full burst.
        startReset();
        for (int j = 0; j < 2; j++) prodQ[2].push_back(8'(8'h60 + j));
        for (int j = 0; j < 4; j++) prodQ[3].push_back(8'(8'h70 + j));
        driveProducers();
        releaseReset(b);
        expectWrite(b + 1, 2, 8'h60);
        expectWrite(b + 2, 2, 8'h61);
        for (int j = 0; j < 4; j++) expectWrite(b + 5 + j, 3, 8'(8'h70 + j));
        expectStatus(b + 3, 1'b1, 2'd2, 4'b0000, 1'b0);
        expectStatus(b + 4, 1'b0, 2'd2, 4'b0000, 1'b0);
        expectStatus(b + 9, 1'b0, 2'd3, 4'b0000, 1'b0);
        repeat (10) tick();

        // Asynchronous reset in the middle of requester 2's burst.
        startReset();
        for (int j = 0; j < 4; j++) prodQ[2].push_back(8'(8'h80 + j));
        driveProducers();
        releaseReset(b);
        expectWrite(b + 1, 2, 8'h80);
        expectStatus(b + 1, 1'b1, 2'd2, 4'b0100, 1'b1);
        expectStatus(b + 2, 1'b0, 2'd0, 4'b0000, 1'b0);
        tick();
        tick();
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) prodQ[i].delete();
        driveProducers();
        tick();
        for (int j = 0; j < 4; j++) prodQ[0].push_back(8'(8'h90 + j));
        for (int j = 0; j < 4; j++) prodQ[2].push_back(8'(8'hB0 + j));
        driveProducers();
        releaseReset(b2);
        for (int j = 0; j < 4; j++) expectWrite(b2 + 1 + j, 0, 8'(8'h90 + j));
        for (int j = 0; j < 4; j++) expectWrite(b2 + 6 + j, 2, 8'(8'hB0 + j));
        expectStatus(b2 + 1, 1'b1, 2'd0, 4'b0001, 1'b1);
        repeat (11) tick();

`ifdef FIFO_WR_ARBITER_STATS_EN
        // Long stall drives the counter into saturation.
        startReset();
        for (int j = 0; j < 4; j++) prodQ[0].push_back(8'(8'hC0 + j));
        driveProducers();
        fifoFull = 1'b1;
        releaseReset(b);
        expectStall(b + 65535, 1'b1, 2'd0, 16'hFFFE);
        expectStall(b + 65536, 1'b1, 2'd0, 16'hFFFF);
        pushCheck(b + 65541, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 8'h00, 1'b1, 16'hFFFF);
        for (int j = 0; j < 4; j++) expectWrite(b + 65541 + j, 0, 8'(8'hC0 + j));
        repeat (65541) tick();
        fifoFull = 1'b0;
        repeat (6) tick();
`endif
    endtask

    // Monitor: compares every write and every scheduled status snapshot on the falling edge.
    task automatic checkOutput();
        wrExp_t w;
        stExp_t s;
        while (wrQ.size() > 0 && wrQ[0].cyc < cycle) begin
            w = wrQ.pop_front();
            vecCount++;
            missCount++;
            $display("[TB] FAIL write@%0d: got no write, want gnt=%b data=%h", w.cyc, w.expGnt, w.expData);
        end
        if (fifoWr || gnt != 4'b0000) begin
            vecCount++;
            if (wrQ.size() == 0) begin
                missCount++;
                $display("[TB] FAIL write@%0d: got wr=%b gnt=%b data=%h, want no write", cycle, fifoWr, gnt, fifoWrData);
            end else begin
                w = wrQ.pop_front();
                if (w.cyc != cycle || !fifoWr || gnt != w.expGnt || fifoWrData != w.expData) begin
                    missCount++;
                    $display("[TB] FAIL write@%0d: got wr=%b gnt=%b data=%h, want cycle %0d gnt=%b data=%h",
                             cycle, fifoWr, gnt, fifoWrData, w.cyc, w.expGnt, w.expData);
                end
            end
        end
        while (stQ.size() > 0 && stQ[0].cyc <= cycle) begin
            s = stQ.pop_front();
            vecCount++;
            if (s.cyc != cycle || busy != s.expBusy || owner != s.expOwner || gnt != s.expGnt || fifoWr != s.expWr) begin
                missCount++;
                $display("[TB] FAIL status@%0d: busy/owner/gnt/wr got %b/%0d/%b/%b want %b/%0d/%b/%b (cycle %0d)",
                         cycle, busy, owner, gnt, fifoWr, s.expBusy, s.expOwner, s.expGnt, s.expWr, s.cyc);
            end
            if (s.chkData) begin
                vecCount++;
                if (fifoWrData != s.expData) begin
                    missCount++;
                    $display("[TB] FAIL wrdata@%0d: got %h want %h", cycle, fifoWrData, s.expData);
                end
            end
`ifdef FIFO_WR_ARBITER_STATS_EN
            if (s.chkStall) begin
                vecCount++;
                if (stallCnt != s.expStall) begin
                    missCount++;
                    $display("[TB] FAIL stall_cnt@%0d: got %h want %h", cycle, stallCnt, s.expStall);
                end
            end
`endif
        end
        if (doneReq) begin
            vecCount++;
            if (wrQ.size() != 0 || stQ.size() != 0) begin
                missCount++;
                $display("[TB] FAIL drain: got %0d writes and %0d checks pending, want 0 and 0", wrQ.size(), stQ.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
            $finish;
        end
    endtask

    always @(negedge clk) checkOutput();

    initial begin
        fifoFull = 1'b0;
        driveProducers();
        applyStimulus();
        doneReq = 1'b1;
    end

endmodule
